// File: rtl/cmem_cache_if.sv
// CPU-side cmem request port plus the line-granular pmem port of one cmem_cache.
// slave = the cache, master = the CPU/memory side driving it.
interface cmem_cache_if;
   logic         cmem_read;
   logic         cmem_write;
   logic [3:0]   cmem_byte_enable;
   logic [31:0]  cmem_address;
   logic [31:0]  cmem_wdata;
   logic         cmem_resp;
   logic [31:0]  cmem_rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   modport slave (
      input  cmem_read, cmem_write, cmem_byte_enable, cmem_address, cmem_wdata,
      output cmem_resp, cmem_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output cmem_read, cmem_write, cmem_byte_enable, cmem_address, cmem_wdata,
      input  cmem_resp, cmem_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/cmem_cache.sv
// Direct-mapped, write-back, write-allocate cache with 256-bit lines over a line pmem.
// Optional CMEM_CACHE_PERF_EN adds saturating perf_hits/perf_misses counters.
module cmem_cache #(
   parameter int S_INDEX  = 3,
   parameter int S_OFFSET = 5
) (
   input  logic clk,
   input  logic rst,
   cmem_cache_if.slave bus
`ifdef CMEM_CACHE_PERF_EN
   ,
   output logic [31:0] perf_hits,
   output logic [31:0] perf_misses
`endif
);
   localparam int SETS  = 2**S_INDEX;
   localparam int TAG_W = 32 - S_OFFSET - S_INDEX;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
   state_t state, state_nxt;

   logic [SETS-1:0]  valid, dirty;
   logic [TAG_W-1:0] tag_arr  [SETS];
   logic [255:0]     data_arr [SETS];

   logic [TAG_W-1:0]   req_tag;
   logic [S_INDEX-1:0] idx;
   logic [2:0]         word;
   logic               request, hit, victim_dirty;
   logic [255:0]       line, merged;
   logic               resp, fill, wb_done, miss_start;
   logic [1:0]         addr_unused;

   assign req_tag      = bus.cmem_address[31 -: TAG_W];
   assign idx          = bus.cmem_address[S_OFFSET +: S_INDEX];
   assign word         = bus.cmem_address[4:2];
   assign addr_unused  = bus.cmem_address[1:0];
   assign request      = bus.cmem_read | bus.cmem_write;
   assign hit          = valid[idx] && (tag_arr[idx] == req_tag);
   assign victim_dirty = valid[idx] && dirty[idx];
   assign line         = data_arr[idx];

   always_comb begin
      merged = line;
      for (int b = 0; b < 4; b++)
         if (bus.cmem_byte_enable[b])
            merged[{word, 5'(b * 8)} +: 8] = bus.cmem_wdata[b*8 +: 8];
   end

   always_comb begin
      state_nxt        = state;
      resp             = 1'b0;
      fill             = 1'b0;
      wb_done          = 1'b0;
      miss_start       = 1'b0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      case (state)
         IDLE: begin
            if (request) begin
               if (hit) begin
                  resp = 1'b1;
               end else begin
                  miss_start = 1'b1;
                  state_nxt  = victim_dirty ? WRITEBACK : ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_arr[idx], idx, {S_OFFSET{1'b0}}};
            bus.pmem_wdata   = line;
            if (bus.pmem_resp) begin
               wb_done   = 1'b1;
               state_nxt = ALLOCATE;
            end
         end
         ALLOCATE: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
            if (bus.pmem_resp) begin
               fill      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Valid is cleared by reset and hits are impossible in reset, so resp is 0 there.
   assign bus.cmem_resp  = resp;
   assign bus.cmem_rdata = resp ? line[{word, 5'd0} +: 32] : 32'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= state_nxt;
         if (resp && bus.cmem_write && (bus.cmem_byte_enable != 4'd0))
            dirty[idx] <= 1'b1;
         if (wb_done)
            dirty[idx] <= 1'b0;
         if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end
      end
   end

   // Tag and data arrays are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (resp && bus.cmem_write)
         data_arr[idx] <= merged;
      if (fill) begin
         data_arr[idx] <= bus.pmem_rdata;
         tag_arr[idx]  <= req_tag;
      end
   end

`ifdef CMEM_CACHE_PERF_EN
   logic missed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_hits   <= '0;
         perf_misses <= '0;
         missed      <= 1'b0;
      end else begin
         if (miss_start) begin
            missed <= 1'b1;
            if (perf_misses != 32'hFFFF_FFFF) perf_misses <= perf_misses + 32'd1;
         end
         if (resp) begin
            missed <= 1'b0;
            if (!missed && perf_hits != 32'hFFFF_FFFF) perf_hits <= perf_hits + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_cmem_cache.sv
// Randomized scoreboard bench for cmem_cache: a line-level cache model predicts
// cmem responses and pmem transactions; monitors compare what the DUT presents.
module tb_cmem_cache;
   localparam int SETS = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cmem_cache_if bus();

`ifdef CMEM_CACHE_PERF_EN
   logic [31:0] perf_hits, perf_misses;
   cmem_cache dut (.clk(clk), .rst(rst), .bus(bus), .perf_hits(perf_hits), .perf_misses(perf_misses));
`else
   cmem_cache dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   typedef struct {bit wr; logic [31:0] rdata; bit hit;} resp_t;
   typedef struct {bit wr; logic [31:0] addr; logic [255:0] data;} pop_t;

   resp_t resp_q[$];
   pop_t  pmem_q[$];
   logic [255:0] mem [int unsigned];

   bit           m_valid [SETS];
   bit           m_dirty [SETS];
   logic [31:0]  m_laddr [SETS];
   logic [255:0] m_line  [SETS];

   int checks = 0, errors = 0;
   bit hold = 1'b0;
   logic [31:0]  last_rdata;
   logic [255:0] last_wb_data;

   task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail(string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [255:0] get_line(logic [31:0] laddr);
      logic [255:0] l;
      if (!mem.exists(laddr)) begin
         for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
         mem[laddr] = l;
      end
      return mem[laddr];
   endfunction

   // Cache behaviour at the level of "which line lives in which set".
   task automatic model_req(bit wr, logic [31:0] addr, logic [3:0] be, logic [31:0] wd);
      int s = int'((addr >> 5) & 32'h7);
      int w = int'((addr >> 2) & 32'h7);
      logic [31:0] laddr = addr & ~32'h1f;
      bit hit = m_valid[s] && (m_laddr[s] == laddr);
      if (!hit) begin
         if (m_valid[s] && m_dirty[s]) begin
            mem[m_laddr[s]] = m_line[s];
            pmem_q.push_back('{1'b1, m_laddr[s], m_line[s]});
         end
         pmem_q.push_back('{1'b0, laddr, 256'd0});
         m_line[s]  = get_line(laddr);
         m_laddr[s] = laddr;
         m_valid[s] = 1'b1;
         m_dirty[s] = 1'b0;
      end
      if (wr) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) m_line[s][w*32 + b*8 +: 8] = wd[b*8 +: 8];
         if (be != 4'd0) m_dirty[s] = 1'b1;
         resp_q.push_back('{1'b1, 32'd0, hit});
      end else begin
         resp_q.push_back('{1'b0, m_line[s][w*32 +: 32], hit});
      end
   endtask

   // Called just after a rising edge; leaves again just after a rising edge.
   task automatic do_req(bit rd, bit wr, logic [31:0] addr, logic [3:0] be, logic [31:0] wd);
      int n = 0;
      model_req(wr, addr, be, wd);
      bus.cmem_read        = rd;
      bus.cmem_write       = wr;
      bus.cmem_address     = addr;
      bus.cmem_byte_enable = be;
      bus.cmem_wdata       = wd;
      forever begin
         @(negedge clk);
         if (bus.cmem_resp) break;
         n++;
         if (n > 200) begin
            fail("request_timeout");
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.cmem_read  = 1'b0;
      bus.cmem_write = 1'b0;
   endtask

   // pmem responder with random latency; stands aside while hold is set.
   initial begin
      int cnt = 0;
      int lat = 0;
      bit driven = 1'b0;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (hold) begin
            cnt = 0;
            driven = 1'b0;
         end else begin
            if (driven) begin
               bus.pmem_resp = 1'b0;
               driven = 1'b0;
            end
            if (rst) begin
               cnt = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
               if (cnt >= lat) begin
                  bus.pmem_resp  = 1'b1;
                  bus.pmem_rdata = mem.exists(bus.pmem_address) ? mem[bus.pmem_address] : 256'd0;
                  driven = 1'b1;
                  cnt = 0;
                  lat = $urandom_range(0, 3);
               end else begin
                  cnt++;
               end
            end
         end
      end
   end

   // Monitor: pmem transactions and cmem responses against the scoreboard queues.
   initial begin
      logic [33:0] prev_op = '0;
      logic [33:0] cur_op;
      int age = 0;
      pop_t  ep;
      resp_t er;
      forever begin
         @(negedge clk);
         cur_op = {bus.pmem_read, bus.pmem_write, bus.pmem_address};
         if ((bus.pmem_read || bus.pmem_write) && cur_op != prev_op) begin
            if (bus.pmem_read && bus.pmem_write) fail("pmem_read_and_write");
            if (pmem_q.size() == 0) begin
               fail("unexpected_pmem_op");
            end else begin
               ep = pmem_q.pop_front();
               chk("pmem_op_is_write", 256'(bus.pmem_write), 256'(ep.wr));
               chk("pmem_address", 256'(bus.pmem_address), 256'(ep.addr));
               if (ep.wr) begin
                  chk("pmem_wdata", bus.pmem_wdata, ep.data);
                  last_wb_data = bus.pmem_wdata;
               end
            end
         end
         prev_op = (bus.pmem_read || bus.pmem_write) ? cur_op : '0;
         if (bus.cmem_resp) begin
            if (bus.pmem_read || bus.pmem_write) fail("cmem_resp_during_pmem_op");
            if (resp_q.size() == 0) begin
               fail("unexpected_cmem_resp");
            end else begin
               er = resp_q.pop_front();
               if (!er.wr) begin
                  chk("cmem_rdata", 256'(bus.cmem_rdata), 256'(er.rdata));
                  last_rdata = bus.cmem_rdata;
               end
               if (er.hit) chk("hit_latency", 256'(age), 256'd0);
               else if (age < 2) fail("miss_resp_too_early");
            end
            age = 0;
         end else if (rst) begin
            age = 0;
         end else if (bus.cmem_read || bus.cmem_write) begin
            age++;
         end
      end
   end

   initial begin
      logic [255:0] l;
      int n;
      int op;
      logic [31:0] tags [4];
      logic [31:0] addr;
      tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h2; tags[3] = 32'h12345;

      bus.cmem_read        = 1'b1;
      bus.cmem_write       = 1'b0;
      bus.cmem_byte_enable = 4'hF;
      bus.cmem_address     = 32'h0000_0104;
      bus.cmem_wdata       = 32'd0;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
      l[63:32] = 32'hDEADBEEF;
      mem[32'h100] = l;

      // A request held during reset must produce nothing.
      #2;
      chk("rst_cmem_resp", 256'(bus.cmem_resp), 256'd0);
      chk("rst_cmem_rdata", 256'(bus.cmem_rdata), 256'd0);
      chk("rst_pmem_read", 256'(bus.pmem_read), 256'd0);
      chk("rst_pmem_write", 256'(bus.pmem_write), 256'd0);
      bus.cmem_read = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_req(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'd0);
      chk("cold_read_data", 256'(last_rdata), 256'(32'hDEADBEEF));
      do_req(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'd0);
      do_req(1'b0, 1'b1, 32'h0000_0104, 4'b0101, 32'hAABBCCDD);
      do_req(1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'd0);
      chk("merged_read_data", 256'(last_rdata), 256'(32'hDEBBBEDD));
      do_req(1'b1, 1'b0, 32'h0000_1100, 4'h0, 32'd0);
      chk("victim_word1", 256'(last_wb_data[63:32]), 256'(32'hDEBBBEDD));
`ifdef CMEM_CACHE_PERF_EN
      chk("perf_hits", 256'(perf_hits), 256'd3);
      chk("perf_misses", 256'(perf_misses), 256'd2);
`endif

      // Abort an allocate with reset; a stray pmem_resp afterwards must be ignored.
      hold = 1'b1;
      void'(get_line(32'h2040));
      pmem_q.push_back('{1'b0, 32'h2040, 256'd0});
      bus.cmem_read    = 1'b1;
      bus.cmem_address = 32'h0000_2040;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.pmem_read) break;
         n++;
         if (n > 20) begin
            fail("allocate_never_started");
            break;
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_pmem_read", 256'(bus.pmem_read), 256'd0);
      chk("abort_cmem_resp", 256'(bus.cmem_resp), 256'd0);
      bus.cmem_read = 1'b0;
      for (int s = 0; s < SETS; s++) begin
         m_valid[s] = 1'b0;
         m_dirty[s] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = {8{32'h5A5A_0F0F}};
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stray_resp_idle", 256'({bus.pmem_read, bus.pmem_write, bus.cmem_resp}), 256'd0);
      end
      hold = 1'b0;
      @(posedge clk);
      #1;
      do_req(1'b1, 1'b0, 32'h0000_2040, 4'h0, 32'd0);

      // Random traffic over a few conflicting tags.
      for (int i = 0; i < 400; i++) begin
         addr = (tags[$urandom_range(0, 3)] << 8) | ($urandom_range(0, 7) << 5)
              | ($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
         op = $urandom_range(0, 9);
         if (op < 5)      do_req(1'b1, 1'b0, addr, 4'($urandom()), $urandom());
         else if (op < 9) do_req(1'b0, 1'b1, addr, 4'($urandom()), $urandom());
         else             do_req(1'b1, 1'b1, addr, 4'($urandom()), $urandom());
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      chk("resp_queue_drained", 256'(resp_q.size()), 256'd0);
      chk("pmem_queue_drained", 256'(pmem_q.size()), 256'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule
